// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    typedef logic [7:0] byte_t;

    localparam int DEFAULT_CLK_PER_BIT = 868;
    localparam int DEFAULT_FIFO_DEPTH  = 16;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: 2-flop synchroniser plus bit-timing FSM; byte_valid pulses in the stop-sample cycle.
// No backpressure: a completed byte is offered for exactly one cycle and must be taken or lost.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_pulse
);

    localparam int TW = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] T_MID  = TW'(CLK_PER_BIT / 2 - 1);

    logic          sync1;
    logic          sync2;
    logic          rxd_prev;
    rx_state_t     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    byte_t         shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            sync1    <= rxd;
            sync2    <= sync1;
            rxd_prev <= sync2;
        end
    end

    // START waits half a bit so every later full-bit sample lands mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (rxd_prev && !sync2) begin
                        state <= START;
                    end
                end
                START: begin
                    if (timer == T_MID) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        shift <= {sync2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from registered state so the FIFO writes on the same edge as the stop sample.
    always_comb begin
        byte_valid      = 1'b0;
        frame_err_pulse = 1'b0;
        byte_data       = shift;
        if (state == STOP && timer == T_LAST) begin
            byte_valid      = sync2;
            frame_err_pulse = !sync2;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive front end: deserialiser feeding a show-ahead byte FIFO with sticky error flags.
// Byte visible one cycle after its stop sample; a full FIFO drops new bytes and sets overrun.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err_pulse;

    byte_t       mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        do_pop;
    logic        do_push;

    uart_rx_core #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_core (
        .clk             (clk),
        .rst             (rst),
        .rxd             (rxd),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .frame_err_pulse (frame_err_pulse)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
    assign do_pop  = rd_en && !empty;
    assign do_push = byte_valid && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= byte_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (byte_valid && full && !do_pop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (frame_err_pulse) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign rx_valid = !empty;
    assign count    = wr_ptr - rd_ptr;
    assign rd_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_buffer;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    // Start bit driven at negedge 0: edge seen at P3, start sample P11, stop sample P155.
    localparam int PUSH_LAT = 155;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] count;
    logic       overrun;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    uart_rx_buffer #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at a negedge with the line idle.
    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = fr[k];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    // Cycle-exact frame; optionally pops in the push cycle.
    task automatic send_timed(input logic [7:0] b, input logic pop_at_push,
                              input logic [7:0] head_before, input logic [7:0] head_after,
                              input logic [2:0] cnt_after);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            rxd = fr[i / CPB];
            if (i == PUSH_LAT - 1) begin
                chk("head_pre_push", {24'd0, rd_data}, {24'd0, head_before});
                rd_en = pop_at_push;
            end
            if (i == PUSH_LAT) begin
                rd_en = 1'b0;
                chk("valid_at_push", {31'd0, rx_valid}, 32'd1);
                chk("head_at_push", {24'd0, rd_data}, {24'd0, head_after});
                chk("count_at_push", {29'd0, count}, {29'd0, cnt_after});
            end
            @(negedge clk);
        end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1: reset state
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_data", {24'd0, rd_data}, 32'h00);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);

        // 2: 0xA5 with exact push latency, then pop
        send_timed(8'hA5, 1'b0, 8'h00, 8'hA5, 3'd1);
        pop_expect("a5_pop", 8'hA5);
        chk("a5_valid_after_pop", {31'd0, rx_valid}, 32'd0);
        chk("a5_data_after_pop", {24'd0, rd_data}, 32'h00);

        // 3: 5-cycle glitch, then 0x3C
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_count", {29'd0, count}, 32'd0);
        send(8'h3C, 1'b1);
        chk("3c_count", {29'd0, count}, 32'd1);
        pop_expect("3c_pop", 8'h3C);

        // 4: framing error and clear
        send(8'h55, 1'b0);
        chk("fe_set", {31'd0, frame_err}, 32'd1);
        chk("fe_count", {29'd0, count}, 32'd0);
        pulse_clr();
        chk("fe_clr", {31'd0, frame_err}, 32'd0);
        send(8'h55, 1'b1);
        chk("55_count", {29'd0, count}, 32'd1);
        pop_expect("55_pop", 8'h55);

        // 5: overrun on the fifth byte
        for (int j = 1; j <= 5; j++) send(8'(j), 1'b1);
        chk("ovr_count", {29'd0, count}, 32'd4);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        for (int j = 1; j <= 4; j++) pop_expect("ovr_order", 8'(j));
        chk("ovr_empty", {31'd0, rx_valid}, 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("pop_empty_count", {29'd0, count}, 32'd0);
        chk("pop_empty_data", {24'd0, rd_data}, 32'h00);

        // 6: push+pop while full, then reset mid-frame
        pulse_clr();
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        for (int j = 2; j <= 5; j++) send(8'(j), 1'b1);
        chk("full_count", {29'd0, count}, 32'd4);
        send_timed(8'h06, 1'b1, 8'h02, 8'h03, 3'd4);
        chk("full_pp_overrun", {31'd0, overrun}, 32'd0);
        for (int j = 3; j <= 6; j++) pop_expect("full_pp_order", 8'(j));
        chk("full_pp_empty", {31'd0, rx_valid}, 32'd0);

        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        chk("pre_rst_count", {29'd0, count}, 32'd1);
        chk("pre_rst_fe", {31'd0, frame_err}, 32'd1);
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'h99, 1'b0};
            for (int i = 0; i < 4 * CPB + 8; i++) begin
                rxd = fr[i / CPB];
                @(negedge clk);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_data", {24'd0, rd_data}, 32'h00);
        chk("mid_rst_fe", {31'd0, frame_err}, 32'd0);
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst_idle", {29'd0, count}, 32'd0);
        send(8'h81, 1'b1);
        chk("post_rst_count", {29'd0, count}, 32'd1);
        chk("post_rst_data", {24'd0, rd_data}, 32'h81);
        chk("post_rst_fe", {31'd0, frame_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
